// File: rtl/dec16_timer.sv
// -----------------------------------------------------------------------------
// dec16_timer
//
// 16-bit loadable countdown timer. A reload register and the counter are
// written together by `load`. While running, each cycle with `tick_en` high
// decrements the counter. The edge that takes the counter from 1 to 0 is the
// terminal tick, and `done` is high for the following cycle. With
// `auto_reload` set and a non-zero reload value, the counter is refilled on
// the terminal tick and keeps running. This gives a periodic interval source.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   load         in   write load_val into reload register and counter
//   load_val     in   [WIDTH-1:0] value to load
//   start        in   IDLE -> RUN request (zero count: immediate done pulse)
//   stop         in   RUN -> IDLE request, count freezes
//   auto_reload  in   on terminal tick, reload and keep running
//   tick_en      in   decrement qualifier, only looked at in RUN
//   count        out  [WIDTH-1:0] current counter value (registered)
//   busy         out  high while in RUN; this is the FSM state itself
//   done         out  one-cycle pulse after the terminal tick (registered)
//
// Control inputs are level-sampled on every rising edge. There is no
// handshake. Priority per edge: reset, load, stop, start, tick.
// -----------------------------------------------------------------------------
module dec16_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic             tick_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            // A load overrides any tick on this edge. No decrement and no done.
            // stop/start still steer the state. A start uses the value being
            // loaded to decide whether there is anything to run.
            count_d  = load_val;
            reload_d = load_val;
            if (stop) begin
                state_d = ST_IDLE;
            end else if (start && state_q == ST_IDLE && load_val != ZERO) begin
                state_d = ST_RUN;
            end
        end else if (stop) begin
            // stop beats start. In IDLE this leaves everything as is.
            state_d = ST_IDLE;
        end else if (start && state_q == ST_IDLE) begin
            if (count_q != ZERO) begin
                state_d = ST_RUN;
            end else begin
                // Zero-length interval: complete immediately.
                done_d = 1'b1;
            end
        end else if (state_q == ST_RUN && tick_en) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (count_q == ONE) begin
                done_d = 1'b1;
                if (auto_reload && reload_q != ZERO) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = ST_IDLE;
                end
            end
            // The counter can be at zero in RUN after a load of zero. It then
            // holds at zero, because the counter never wraps.
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;

endmodule

// File: tb/tb_dec16_timer.sv
// Directed bench for dec16_timer. Inputs change 1 ns after a rising edge.
// Outputs are checked at that same point, so they reflect the edge just taken.
module tb_dec16_timer;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        auto_reload;
  logic        tick_en;
  logic [15:0] count;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  dec16_timer #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .tick_en     (tick_en),
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_count,
                         input logic e_busy, input logic e_done);
    chk({tag, ".count"}, {16'h0, count}, {16'h0, e_count});
    chk({tag, ".busy"},  {31'h0, busy},  {31'h0, e_busy});
    chk({tag, ".done"},  {31'h0, done},  {31'h0, e_done});
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  logic [15:0] exp_cnt;
  int          done_seen;

  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    load_val = 16'h0;
    start = 1'b0;
    stop = 1'b0;
    auto_reload = 1'b0;
    tick_en = 1'b0;
    #3;
    chk_out("reset", 16'h0000, 1'b0, 1'b0);
    #10 rst_n = 1'b1;
    step();

    // one-shot: load 3, start, continuous ticks
    do_load(16'h0003);
    chk_out("os_load", 16'h0003, 1'b0, 1'b0);
    start = 1'b1;
    tick_en = 1'b1;
    step();
    start = 1'b0;
    chk_out("os_start", 16'h0003, 1'b1, 1'b0);
    step();
    chk_out("os_t1", 16'h0002, 1'b1, 1'b0);
    step();
    chk_out("os_t2", 16'h0001, 1'b1, 1'b0);
    step();
    chk_out("os_term", 16'h0000, 1'b0, 1'b1);
    step();
    chk_out("os_after", 16'h0000, 1'b0, 1'b0);

    // auto-reload with period 2
    auto_reload = 1'b1;
    do_load(16'h0002);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("ar_start", 16'h0002, 1'b1, 1'b0);
    step();
    chk_out("ar_c1", 16'h0001, 1'b1, 1'b0);
    step();
    chk_out("ar_rl1", 16'h0002, 1'b1, 1'b1);
    step();
    chk_out("ar_c1b", 16'h0001, 1'b1, 1'b0);
    step();
    chk_out("ar_rl2", 16'h0002, 1'b1, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    auto_reload = 1'b0;
    chk_out("ar_stop", 16'h0002, 1'b0, 1'b0);

    // gated ticks down to 0xF0, then stop and resume
    tick_en = 1'b0;
    do_load(16'h00FF);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("gt_start", 16'h00FF, 1'b1, 1'b0);
    exp_cnt = 16'h00FF;
    for (int i = 0; i < 30; i++) begin
      tick_en = (i % 2 == 0);
      if (tick_en) exp_cnt = exp_cnt - 16'd1;
      step();
      chk("gt_count", {16'h0, count}, {16'h0, exp_cnt});
    end
    chk_out("gt_f0", 16'h00F0, 1'b1, 1'b0);
    stop = 1'b1;
    tick_en = 1'b1;
    step();
    stop = 1'b0;
    chk_out("gt_stop", 16'h00F0, 1'b0, 1'b0);
    step();
    step();
    chk_out("gt_idle_hold", 16'h00F0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("gt_restart", 16'h00F0, 1'b1, 1'b0);
    step();
    chk_out("gt_resume", 16'h00EF, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // zero-length interval
    do_load(16'h0000);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("zero_start", 16'h0000, 1'b0, 1'b1);
    step();
    chk_out("zero_after", 16'h0000, 1'b0, 1'b0);

    // load collides with terminal tick
    do_load(16'h0002);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_out("col_at1", 16'h0001, 1'b1, 1'b0);
    load = 1'b1;
    load_val = 16'h0010;
    step();
    load = 1'b0;
    chk_out("col_load", 16'h0010, 1'b1, 1'b0);
    step();
    chk_out("col_next", 16'h000F, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // start and stop together in IDLE
    do_load(16'h0005);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk_out("ss_idle", 16'h0005, 1'b0, 1'b0);

    // asynchronous reset mid-RUN at count 5
    tick_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("rst_pre", 16'h0005, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("rst_async", 16'h0000, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_out("rst_idle_ticks", 16'h0000, 1'b0, 1'b0);

    // full-range interval: 0xFFFF gives 65535 ticks to terminal
    do_load(16'hFFFF);
    start = 1'b1;
    step();
    start = 1'b0;
    chk_out("max_start", 16'hFFFF, 1'b1, 1'b0);
    done_seen = 0;
    for (int i = 0; i < 65534; i++) begin
      step();
      if (done) done_seen++;
    end
    chk("max_early_done", done_seen, 0);
    chk_out("max_at1", 16'h0001, 1'b1, 1'b0);
    step();
    chk_out("max_term", 16'h0000, 1'b0, 1'b1);
    step();
    chk_out("max_after", 16'h0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
